// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard decoder: prefix and modifier
// scan codes, event-word bit positions, ASCII lookup and the prefix FSM states.
package keyboard_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // E1 starts the pause sequence; the remaining seven bytes carry no key.
  localparam logic [2:0] SKIP_LEN = 3'd7;

  localparam int EV_BREAK    = 15;
  localparam int EV_EXT      = 14;
  localparam int EV_SHIFT    = 13;
  localparam int EV_CTRL     = 12;
  localparam int EV_ALT      = 11;
  localparam int EV_CAPS     = 10;
  localparam int EV_ASCII_OK = 9;

  typedef enum logic [2:0] {
    KBD_IDLE,
    KBD_EXT,
    KBD_BRK,
    KBD_EXTBRK,
    KBD_SKIP
  } kbd_state_t;

  // Controller responses and error bytes that never start a key.
  function automatic logic is_discard(input logic [7:0] code);
    return code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  function automatic logic is_letter(input logic [7:0] ch);
    return (ch >= 8'h61) && (ch <= 8'h7A);
  endfunction

  // Returns 8'h00 for unmapped codes, which the decoder reads as ascii_ok=0.
  function automatic logic [7:0] ascii_unshifted(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
      8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
      8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
      8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
      8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
      8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
      8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
      8'h0D: return 8'h09;  8'h76: return 8'h1B;  8'h0E: return 8'h60;
      8'h4E: return 8'h2D;  8'h55: return 8'h3D;  8'h54: return 8'h5B;
      8'h5B: return 8'h5D;  8'h5D: return 8'h5C;  8'h4C: return 8'h3B;
      8'h52: return 8'h27;  8'h41: return 8'h2C;  8'h49: return 8'h2E;
      8'h4A: return 8'h2F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ascii_shifted(input logic [7:0] code);
    logic [7:0] base;
    base = ascii_unshifted(code);
    if (is_letter(base)) return base ^ 8'h20;
    case (code)
      8'h45: return 8'h29;  8'h16: return 8'h21;  8'h1E: return 8'h40;
      8'h26: return 8'h23;  8'h25: return 8'h24;  8'h2E: return 8'h25;
      8'h36: return 8'h5E;  8'h3D: return 8'h26;  8'h3E: return 8'h2A;
      8'h46: return 8'h28;  8'h0E: return 8'h7E;  8'h4E: return 8'h5F;
      8'h55: return 8'h2B;  8'h54: return 8'h7B;  8'h5B: return 8'h7D;
      8'h5D: return 8'h7C;  8'h4C: return 8'h3A;  8'h52: return 8'h22;
      8'h41: return 8'h3C;  8'h49: return 8'h3E;  8'h4A: return 8'h3F;
      default: return base;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_fifo.sv
// Synchronous show-ahead FIFO; a push while full without a pop is dropped.
// Pointers carry one extra bit so full and empty are told apart by the MSB.
module keyboard_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 byte decoder: prefix FSM, modifier/caps tracking, ASCII translation
// and an event FIFO. Define KBD_BREAK_EVENTS_EN to also queue non-modifier breaks.
module keyboard_decoder
  import keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  keyboard_code,
  input  logic        keyboard_strobe,
  input  logic        rd_strobe,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        overflow,
  input  logic        clear_overflow
);

`ifdef KBD_BREAK_EVENTS_EN
  localparam logic BREAK_EVENTS = 1'b1;
`else
  localparam logic BREAK_EVENTS = 1'b0;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);

  kbd_state_t  state_q, state_d;
  logic [2:0]  skip_cnt_q, skip_cnt_d;
  logic        shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic        ctrl_q, ctrl_d, alt_q, alt_d, caps_q, caps_d;
  logic        push_q, push_d;
  logic [15:0] event_q, event_d;
  logic        overflow_q;

  logic        key_valid, key_ext, key_brk, is_mod, shift;
  logic        letter, upper, ascii_ok;
  logic [7:0]  ascii_lo, ascii_ch;

  logic [15:0] fifo_data;
  logic        fifo_empty, fifo_full;
  logic [AW:0] fifo_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= KBD_IDLE;
      skip_cnt_q <= '0;
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      ctrl_q     <= 1'b0;
      alt_q      <= 1'b0;
      caps_q     <= 1'b0;
      push_q     <= 1'b0;
      event_q    <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      ctrl_q     <= ctrl_d;
      alt_q      <= alt_d;
      caps_q     <= caps_d;
      push_q     <= push_d;
      event_q    <= event_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (keyboard_strobe) begin
      unique case (state_q)
        KBD_IDLE: begin
          if (keyboard_code == SC_E0)      state_d = KBD_EXT;
          else if (keyboard_code == SC_F0) state_d = KBD_BRK;
          else if (keyboard_code == SC_E1) begin
            state_d    = KBD_SKIP;
            skip_cnt_d = SKIP_LEN;
          end
        end
        KBD_EXT:             state_d = (keyboard_code == SC_F0) ? KBD_EXTBRK : KBD_IDLE;
        KBD_BRK, KBD_EXTBRK: state_d = KBD_IDLE;
        KBD_SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = KBD_IDLE;
        end
        default:             state_d = KBD_IDLE;
      endcase
    end
  end

  always_comb begin
    key_valid = 1'b0;
    key_ext   = 1'b0;
    key_brk   = 1'b0;
    if (keyboard_strobe) begin
      unique case (state_q)
        KBD_IDLE:   key_valid = !(keyboard_code inside {SC_E0, SC_F0, SC_E1}) &&
                                !is_discard(keyboard_code);
        KBD_EXT:    begin key_valid = (keyboard_code != SC_F0); key_ext = 1'b1; end
        KBD_BRK:    begin key_valid = 1'b1; key_brk = 1'b1; end
        KBD_EXTBRK: begin key_valid = 1'b1; key_ext = 1'b1; key_brk = 1'b1; end
        default:    key_valid = 1'b0;
      endcase
    end

    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    ctrl_d    = ctrl_q;
    alt_d     = alt_q;
    caps_d    = caps_q;
    is_mod    = 1'b0;
    if (key_valid) begin
      if (!key_ext && keyboard_code == SC_LSHIFT) begin shift_l_d = !key_brk; is_mod = 1'b1; end
      if (!key_ext && keyboard_code == SC_RSHIFT) begin shift_r_d = !key_brk; is_mod = 1'b1; end
      if (keyboard_code == SC_CTRL)               begin ctrl_d    = !key_brk; is_mod = 1'b1; end
      if (keyboard_code == SC_ALT)                begin alt_d     = !key_brk; is_mod = 1'b1; end
      if (!key_ext && keyboard_code == SC_CAPS) begin
        if (!key_brk) caps_d = !caps_q;
        is_mod = 1'b1;
      end
    end

    // Translation and modifier bits use the state held before this byte.
    shift    = shift_l_q | shift_r_q;
    ascii_lo = ascii_unshifted(keyboard_code);
    letter   = is_letter(ascii_lo);
    upper    = letter ? (shift ^ caps_q) : shift;
    ascii_ch = upper ? ascii_shifted(keyboard_code) : ascii_lo;
    if (ctrl_q && letter) ascii_ch = ascii_ch & 8'h1F;
    ascii_ok = !key_ext && (ascii_lo != 8'h00);

    push_d               = key_valid && !is_mod && (!key_brk || BREAK_EVENTS);
    event_d              = '0;
    event_d[EV_BREAK]    = key_brk;
    event_d[EV_EXT]      = key_ext;
    event_d[EV_SHIFT]    = shift;
    event_d[EV_CTRL]     = ctrl_q;
    event_d[EV_ALT]      = alt_q;
    event_d[EV_CAPS]     = caps_q;
    event_d[EV_ASCII_OK] = ascii_ok;
    event_d[7:0]         = ascii_ok ? ascii_ch : keyboard_code;
  end

  keyboard_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_q),
    .data_i  (event_q),
    .pop_i   (rd_strobe),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // A drop is a push into a full FIFO with no pop alongside; set beats clear.
  always_ff @(posedge clock) begin
    if (reset)                                 overflow_q <= 1'b0;
    else if (push_q && fifo_full && !rd_strobe) overflow_q <= 1'b1;
    else if (clear_overflow)                   overflow_q <= 1'b0;
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = fifo_empty ? 16'h0000 : fifo_data;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Bench for keyboard_decoder: directed scan-code sequences plus random traffic,
// both checked every cycle against a queue-based reference model.
module tb_keyboard_decoder;

  localparam int DEPTH = 16;
`ifdef KBD_BREAK_EVENTS_EN
  localparam bit BRK_EV = 1'b1;
`else
  localparam bit BRK_EV = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  keyboard_code = '0;
  logic        keyboard_strobe = 1'b0;
  logic        rd_strobe = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        overflow;

  always #5 clock = ~clock;

  keyboard_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .keyboard_code   (keyboard_code),
    .keyboard_strobe (keyboard_strobe),
    .rd_strobe       (rd_strobe),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .overflow        (overflow),
    .clear_overflow  (clear_overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic [7:0]  lo_tab [256];
  logic [7:0]  hi_tab [256];
  bit          m_sl, m_sr, m_ctrl, m_alt, m_caps, m_ext, m_brk, m_ovf, pend_v;
  int          m_skip;
  logic [15:0] pend_ev;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};
  logic [7:0] pun_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                 8'h41, 8'h49, 8'h4A};
  logic [7:0] pun_lo [11]    = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] pun_hi [11]    = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] ctl_codes [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] ctl_chars [5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
  logic [7:0] pool [20]      = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h0E,
                                 8'h4A, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'hE0, 8'hF0,
                                 8'hE1, 8'h75, 8'hAA, 8'h00};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_tables();
    string hi_s;
    for (int i = 0; i < 256; i++) begin lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; end
    for (int i = 0; i < 26; i++) begin
      lo_tab[let_codes[i]] = 8'h61 + 8'(i);
      hi_tab[let_codes[i]] = 8'h41 + 8'(i);
    end
    hi_s = ")!@#$%^&*(";
    for (int i = 0; i < 10; i++) begin
      lo_tab[dig_codes[i]] = 8'h30 + 8'(i);
      hi_tab[dig_codes[i]] = hi_s[i];
    end
    for (int i = 0; i < 11; i++) begin
      lo_tab[pun_codes[i]] = pun_lo[i];
      hi_tab[pun_codes[i]] = pun_hi[i];
    end
    for (int i = 0; i < 5; i++) begin
      lo_tab[ctl_codes[i]] = ctl_chars[i];
      hi_tab[ctl_codes[i]] = ctl_chars[i];
    end
  endtask

  // Interpret one received byte; may leave an event pending for the FIFO.
  task automatic model_byte(input logic [7:0] b);
    bit ext, brk, shift, letter, up, ok;
    logic [7:0] ch;
    if (m_skip > 0) begin m_skip--; return; end
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) begin m_ext = 1; return; end
      if (b == 8'hF0) begin m_brk = 1; return; end
      if (b == 8'hE1) begin m_skip = 7; return; end
      if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) return;
    end else if (m_ext && !m_brk && b == 8'hF0) begin
      m_brk = 1;
      return;
    end
    ext = m_ext; brk = m_brk; m_ext = 0; m_brk = 0;
    shift = m_sl | m_sr;
    if (!ext && b == 8'h12) begin m_sl = !brk; return; end
    if (!ext && b == 8'h59) begin m_sr = !brk; return; end
    if (b == 8'h14) begin m_ctrl = !brk; return; end
    if (b == 8'h11) begin m_alt = !brk; return; end
    if (!ext && b == 8'h58) begin if (!brk) m_caps = !m_caps; return; end
    if (brk && !BRK_EV) return;
    ok     = !ext && lo_tab[b] != 8'h00;
    letter = lo_tab[b] >= 8'h61 && lo_tab[b] <= 8'h7A;
    up     = letter ? (shift ^ m_caps) : shift;
    ch     = up ? hi_tab[b] : lo_tab[b];
    if (m_ctrl && letter) ch = ch & 8'h1F;
    pend_v  = 1;
    pend_ev = {brk, ext, shift, m_ctrl, m_alt, m_caps, ok, 1'b0, ok ? ch : b};
  endtask

  task automatic model_edge(input bit rst, input bit stb, input logic [7:0] code,
                            input bit pop, input bit clr);
    bit dropped;
    if (rst) begin
      exp_q.delete();
      {m_sl, m_sr, m_ctrl, m_alt, m_caps, m_ext, m_brk, m_ovf, pend_v} = '0;
      m_skip = 0;
      return;
    end
    dropped = 0;
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (pend_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pend_ev);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    pend_v = 0;
    if (stb) model_byte(code);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cycle(input bit rst, input bit stb, input logic [7:0] code,
                       input bit pop, input bit clr);
    reset = rst; keyboard_strobe = stb; keyboard_code = code;
    rd_strobe = pop; clear_overflow = clr;
    @(posedge clock);
    model_edge(rst, stb, code, pop, clr);
    #1;
    chk("rd_valid", {15'b0, rd_valid}, {15'b0, exp_q.size() != 0});
    chk("rd_data", rd_data, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
    chk("overflow", {15'b0, overflow}, {15'b0, m_ovf});
  endtask

  task automatic send(input logic [7:0] code); cycle(0, 1, code, 0, 0); endtask
  task automatic pop1(); cycle(0, 0, 8'h00, 1, 0); endtask
  task automatic do_reset(); cycle(1, 0, 8'h00, 0, 0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    int pop_w;
    logic [7:0] code;
    build_tables();
    do_reset();
    do_reset();
    chk("rst_valid", {15'b0, rd_valid}, 16'h0000);
    chk("rst_data", rd_data, 16'h0000);
    chk("rst_ovf", {15'b0, overflow}, 16'h0000);

    // Plain make: 'a', visible two cycles after the strobe
    send(8'h1C);
    chk("a_lat1", {15'b0, rd_valid}, 16'h0000);
    idle(1);
    chk("a_valid", {15'b0, rd_valid}, 16'h0001);
    chk("a_data", rd_data, 16'h0261);
    pop1();
    chk("a_pop", {15'b0, rd_valid}, 16'h0000);

    // Shifted 'A' with breaks
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    idle(2);
    chk("shiftA", rd_data, 16'h2241);
    pop1();
`ifdef KBD_BREAK_EVENTS_EN
    chk("shiftA_brk", rd_data, 16'hA241);
    pop1();
`endif
    chk("shiftA_only", {15'b0, rd_valid}, 16'h0000);

    // Caps lock then shift XOR caps
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h12); send(8'h1C);
    idle(2);
    chk("caps_A", rd_data, 16'h0641);
    pop1();
    chk("caps_shift_a", rd_data, 16'h2661);
    pop1();
    chk("caps_empty", {15'b0, rd_valid}, 16'h0000);

    // Ctrl-C and extended up arrow
    do_reset();
    send(8'h14); send(8'h21); idle(2);
    chk("ctrl_c", rd_data, 16'h1203);
    do_reset();
    send(8'hE0); send(8'h75); idle(2);
    chk("ext_up", rd_data, 16'h4075);

    // Pause sequence is swallowed, then space
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h29); idle(2);
    chk("pause_space", rd_data, 16'h0220);
    pop1();
    chk("pause_single", {15'b0, rd_valid}, 16'h0000);

    // 17 makes without pops; the drop coincides with a clear request
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h1C);
    cycle(0, 0, 8'h00, 0, 1);
    chk("ovf_set_prio", {15'b0, overflow}, 16'h0001);
    cycle(0, 0, 8'h00, 0, 1);
    chk("ovf_clear", {15'b0, overflow}, 16'h0000);
    for (int i = 0; i < 16; i++) pop1();
    chk("ovf_16_only", {15'b0, rd_valid}, 16'h0000);

    // Pop and push together on a full FIFO
    do_reset();
    for (int i = 0; i < 16; i++) send(8'h1C);
    idle(2);
    send(8'h32);
    pop1();
    idle(1);
    chk("full_pp_ovf", {15'b0, overflow}, 16'h0000);
    for (int i = 0; i < 15; i++) pop1();
    chk("full_pp_tail", rd_data, 16'h0262);

    // Reset mid-prefix
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h1C); idle(2);
    chk("rst_mid_ext", rd_data, 16'h0261);

    // Random traffic, filling phase then draining phase
    do_reset();
    for (int n = 0; n < 6000; n++) begin
      pop_w = (n < 3000) ? 1 : 3;
      if ($urandom_range(0, 3) == 0) code = 8'($urandom_range(0, 255));
      else code = pool[$urandom_range(0, 19)];
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, code,
            $urandom_range(0, 7) < pop_w, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
